spi_fsm: RTL and testbench
==========================

SPI_FSM -- requirements
Module: spi_fsm

Interface
REQ-001 Parameter: FRAME_BITS, default 8, SCLK rising edges per address frame and per data frame.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 cs_n  input  1  conditioned chip select, level, active-low.
REQ-005 sclk_pe  input  1  one-clk pulse per conditioned SCLK rising edge; drives the shift register's peripheral clock edge input.
REQ-006 rw_bit  input  1  shift register parallel output bit 0; 1 = read, 0 = write.
REQ-007 addr_we  output  1  one-clk pulse latching shift register contents as the address.
REQ-008 sr_we  output  1  one-clk pulse parallel-loading the shift register from data memory.
REQ-009 dm_we  output  1  one-clk pulse writing shift register contents to data memory.
REQ-010 miso_buff  output  1  MISO tristate enable, level.
REQ-011 busy  output  1  high in every state except IDLE.

Function
REQ-012 States SHALL be IDLE, GET_ADDR, GOT_ADDR, READ_LOAD, READ_SHIFT, WRITE_SHIFT, WRITE_STORE, DONE.
REQ-013 Outputs SHALL be registered Moore outputs: addr_we only in GOT_ADDR; sr_we only in READ_LOAD; dm_we only in WRITE_STORE; miso_buff only in READ_SHIFT.
REQ-014 IDLE: cs_n low -> GET_ADDR, bit counter cleared.
REQ-015 GET_ADDR: each sclk_pe increments the counter; the FRAME_BITS-th pulse -> GOT_ADDR, counter cleared.
REQ-016 GOT_ADDR: one cycle; rw_bit=1 -> READ_LOAD, rw_bit=0 -> WRITE_SHIFT.
REQ-017 READ_LOAD: one cycle -> READ_SHIFT.
REQ-018 READ_SHIFT and WRITE_SHIFT: count sclk_pe; the FRAME_BITS-th pulse -> DONE from READ_SHIFT, -> WRITE_STORE from WRITE_SHIFT.
REQ-019 WRITE_STORE: one cycle -> DONE.
REQ-020 DONE: hold with all strobes low until cs_n high; further sclk_pe ignored.
REQ-021 cs_n high in any non-IDLE state -> IDLE next cycle, counter cleared. This has priority over every other transition, including a coincident sclk_pe.
REQ-022 sclk_pe in GOT_ADDR, READ_LOAD or WRITE_STORE SHALL be ignored. Required SCLK period is at least 4 clk cycles.
REQ-023 Counter width SHALL be $clog2(FRAME_BITS+1). The counter SHALL never exceed FRAME_BITS and SHALL clear on every frame completion (no wrap-around).
REQ-024 Latency: the FRAME_BITS-th address sclk_pe -> addr_we high exactly 1 cycle later. The FRAME_BITS-th write-data sclk_pe -> dm_we high exactly 1 cycle later.

Reset
REQ-025 reset_n low SHALL asynchronously force IDLE, clear the counter and drive all outputs low. This applies mid-transaction.
REQ-026 After reset_n rises, a cs_n already low SHALL start GET_ADDR on the next clk edge.

Configuration
REQ-027 Macro SPI_FSM_ABORT_FLAG_EN defined: adds output abort (1 bit, registered). abort pulses high for one cycle when REQ-021 fires from any state other than DONE. Reset value 0.
REQ-028 Macro undefined: no abort port and no abort logic. All other behaviour is identical.

Structure
REQ-029 Shared package spi_pkg SHALL hold the state enum and the FRAME_BITS default constant.
REQ-030 Sub-module spi_bit_counter SHALL implement the counter, with ports clear, inc and terminal-count out.

Verification
REQ-031 Write: cs_n low, 8 pulses with address byte 0x2A (rw_bit=0), then 8 data pulses, then cs_n high. Required response: one addr_we pulse, one dm_we pulse 1 cycle after the 16th pulse, miso_buff stays 0, busy falls 1 cycle after cs_n rises.
REQ-032 Read: address byte 0x55 (rw_bit=1). Required response: addr_we, then sr_we exactly 1 cycle later, then miso_buff high for the 8 data pulses, then miso_buff low in DONE, dm_we never asserted.
REQ-033 Abort: cs_n high after 5 address pulses. Required response: IDLE next cycle, no strobes; with SPI_FSM_ABORT_FLAG_EN, one abort pulse.
REQ-034 Coincidence: cs_n high in the same cycle as the 8th write-data pulse. Required response: IDLE, no dm_we.
REQ-035 Reset: reset_n low in READ_SHIFT after 3 pulses. Required response: outputs 0 immediately without a clk edge, then a fresh 16-pulse write completes normally.
REQ-036 Extra pulses: 12 data pulses in a read. Required response: DONE after the 8th, pulses 9-12 ignored, busy stays high until cs_n high.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave sequencing FSM: state encoding and
// the default frame length.
package spi_pkg;

    localparam int FRAME_BITS_DEFAULT = 8;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        GET_ADDR    = 3'd1,
        GOT_ADDR    = 3'd2,
        READ_LOAD   = 3'd3,
        READ_SHIFT  = 3'd4,
        WRITE_SHIFT = 3'd5,
        WRITE_STORE = 3'd6,
        DONE        = 3'd7
    } spiState_e;

endpackage

// File: rtl/spi_bit_counter.sv
// SCLK edge counter for one frame. tc is combinational: it flags the pulse
// that completes the frame, so the FSM can leave the shift state on that
// same edge and clear the count. The count therefore never reaches
// FRAME_BITS and never wraps.
module spi_bit_counter
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic inc,
    output logic tc
);

    localparam int CW = $clog2(FRAME_BITS + 1);

    logic [CW-1:0] count;

    // Terminal count: the pulse being counted now is the last of the frame.
    always_comb begin
        tc = inc && (count == CW'(FRAME_BITS - 1));
    end

    // Count register; clear wins over inc.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/spi_fsm.sv
// SPI slave transaction sequencer: address frame, then a read or write data
// frame, driving shift-register / data-memory strobes.
// Optional feature: define SPI_FSM_ABORT_FLAG_EN to add the abort output,
// a one-cycle pulse when chip select is withdrawn mid-transaction.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// IDLE        | chip select inactive, waiting for cs_n low
// GET_ADDR    | counting address SCLK edges
// GOT_ADDR    | address latched (addr_we), decode rw_bit
// READ_LOAD   | shift register loaded from data memory (sr_we)
// READ_SHIFT  | shifting read data out, MISO driven (miso_buff)
// WRITE_SHIFT | shifting write data in
// WRITE_STORE | shift register written to data memory (dm_we)
// DONE        | frame complete, wait for cs_n high, SCLK ignored
module spi_fsm
    import spi_pkg::*;
#(
    parameter int FRAME_BITS = FRAME_BITS_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic cs_n,
    input  logic sclk_pe,
    input  logic rw_bit,
    output logic addr_we,
    output logic sr_we,
    output logic dm_we,
    output logic miso_buff,
    output logic busy
`ifdef SPI_FSM_ABORT_FLAG_EN
    ,
    output logic abort
`endif
);

    spiState_e state;
    spiState_e stateNext;
    logic      cntInc;
    logic      cntClear;
    logic      cntTc;

    spi_bit_counter #(
        .FRAME_BITS (FRAME_BITS)
    ) uBitCounter (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (cntClear),
        .inc     (cntInc),
        .tc      (cntTc)
    );

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next state and counter control. The counter is held clear outside the
    // three shift states, so entering any of them always starts from zero.
    always_comb begin
        stateNext = state;
        cntInc    = 1'b0;
        cntClear  = 1'b1;
        if (cs_n && (state != IDLE)) begin
            stateNext = IDLE;
        end else begin
            unique case (state)
                IDLE:        if (!cs_n) stateNext = GET_ADDR;
                GET_ADDR: begin
                    cntInc   = sclk_pe;
                    cntClear = cntTc;
                    if (cntTc) stateNext = GOT_ADDR;
                end
                GOT_ADDR:    stateNext = rw_bit ? READ_LOAD : WRITE_SHIFT;
                READ_LOAD:   stateNext = READ_SHIFT;
                READ_SHIFT: begin
                    cntInc   = sclk_pe;
                    cntClear = cntTc;
                    if (cntTc) stateNext = DONE;
                end
                WRITE_SHIFT: begin
                    cntInc   = sclk_pe;
                    cntClear = cntTc;
                    if (cntTc) stateNext = WRITE_STORE;
                end
                WRITE_STORE: stateNext = DONE;
                DONE:        stateNext = DONE;
                default:     stateNext = IDLE;
            endcase
        end
    end

    // Moore outputs registered from the next-state decode, so each strobe is
    // a clean flop output aligned with the state it belongs to.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_we   <= 1'b0;
            sr_we     <= 1'b0;
            dm_we     <= 1'b0;
            miso_buff <= 1'b0;
            busy      <= 1'b0;
        end else begin
            addr_we   <= (stateNext == GOT_ADDR);
            sr_we     <= (stateNext == READ_LOAD);
            dm_we     <= (stateNext == WRITE_STORE);
            miso_buff <= (stateNext == READ_SHIFT);
            busy      <= (stateNext != IDLE);
        end
    end

`ifdef SPI_FSM_ABORT_FLAG_EN
    // Abort flag: chip select withdrawn before the transaction reached DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            abort <= 1'b0;
        end else begin
            abort <= cs_n && (state != IDLE) && (state != DONE);
        end
    end
`endif

endmodule

// File: tb/tb_spi_fsm.sv
// Self-checking bench for spi_fsm (FRAME_BITS = 8). Expected output words
// are queued when a cycle's inputs are driven and popped after the edge.
// Output word layout: {abort, addr_we, sr_we, dm_we, miso_buff, busy}.
module tb_spi_fsm;

    logic clk     = 1'b0;
    logic reset_n = 1'b0;
    logic cs_n    = 1'b1;
    logic sclk_pe = 1'b0;
    logic rw_bit  = 1'b0;
    logic addr_we, sr_we, dm_we, miso_buff, busy;
    logic abort;

`ifdef SPI_FSM_ABORT_FLAG_EN
    localparam logic AB = 1'b1;
`else
    localparam logic AB = 1'b0;
    assign abort = 1'b0;
`endif

    localparam logic [5:0] NONE = 6'b000000;
    localparam logic [5:0] BUSY = 6'b000001;
    localparam logic [5:0] MISO = 6'b000010;
    localparam logic [5:0] DM   = 6'b000100;
    localparam logic [5:0] SR   = 6'b001000;
    localparam logic [5:0] ADDR = 6'b010000;
    localparam logic [5:0] ABRT = {AB, 5'b00000};

    always #5 clk = ~clk;

    spi_fsm dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cs_n      (cs_n),
        .sclk_pe   (sclk_pe),
        .rw_bit    (rw_bit),
        .addr_we   (addr_we),
        .sr_we     (sr_we),
        .dm_we     (dm_we),
        .miso_buff (miso_buff),
        .busy      (busy)
`ifdef SPI_FSM_ABORT_FLAG_EN
        ,
        .abort     (abort)
`endif
    );

    typedef struct {
        logic       cs;
        logic       pe;
        logic       rw;
        int         reps;
        logic [5:0] exp;
    } vec_t;

    vec_t       vecs[$];
    logic [5:0] sbq[$];
    int         checks = 0;
    int         errors = 0;

    function automatic logic [5:0] outs();
        return {abort, addr_we, sr_we, dm_we, miso_buff, busy};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // One clk cycle: drive inputs at negedge, queue expectation, compare after posedge.
    task automatic step(input string name, input logic cs, input logic pe,
                        input logic rw, input logic [5:0] exp);
        @(negedge clk);
        cs_n    = cs;
        sclk_pe = pe;
        rw_bit  = rw;
        sbq.push_back(exp);
        @(posedge clk);
        #1;
        if (sbq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty, got %b", name, outs());
        end else begin
            check(name, outs(), sbq.pop_front());
        end
    endtask

    // n SCLK periods of 4 clk: one pulse cycle then three quiet cycles.
    task automatic pulses(input string name, input int n, input logic rw,
                          input logic [5:0] expPe, input logic [5:0] expIdle);
        repeat (n) begin
            step(name, 1'b0, 1'b1, rw, expPe);
            repeat (3) step(name, 1'b0, 1'b0, rw, expIdle);
        end
    endtask

    task automatic add(input logic cs, input logic pe, input logic rw,
                       input int reps, input logic [5:0] exp);
        vec_t v;
        v.cs = cs; v.pe = pe; v.rw = rw; v.reps = reps; v.exp = exp;
        vecs.push_back(v);
    endtask

    task automatic runTable(input string name);
        for (int i = 0; i < vecs.size(); i++) begin
            repeat (vecs[i].reps) step(name, vecs[i].cs, vecs[i].pe, vecs[i].rw, vecs[i].exp);
        end
    endtask

    // Write, address 0x2A (bit0 = 0), then 8 data pulses, then cs_n high.
    task automatic buildWrite();
        vecs.delete();
        add(1'b0, 1'b0, 1'b0, 1, BUSY);
        for (int i = 0; i < 7; i++) begin
            add(1'b0, 1'b1, 1'b0, 1, BUSY);
            add(1'b0, 1'b0, 1'b0, 3, BUSY);
        end
        add(1'b0, 1'b1, 1'b0, 1, ADDR | BUSY);
        add(1'b0, 1'b0, 1'b0, 3, BUSY);
        for (int i = 0; i < 7; i++) begin
            add(1'b0, 1'b1, 1'b0, 1, BUSY);
            add(1'b0, 1'b0, 1'b0, 3, BUSY);
        end
        add(1'b0, 1'b1, 1'b0, 1, DM | BUSY);
        add(1'b0, 1'b0, 1'b0, 3, BUSY);
        add(1'b1, 1'b0, 1'b0, 1, NONE);
        add(1'b1, 1'b0, 1'b0, 2, NONE);
    endtask

    // Read, address 0x55 (bit0 = 1), 12 data pulses (9-12 land in DONE).
    task automatic buildRead();
        vecs.delete();
        add(1'b0, 1'b0, 1'b1, 1, BUSY);
        for (int i = 0; i < 7; i++) begin
            add(1'b0, 1'b1, 1'b1, 1, BUSY);
            add(1'b0, 1'b0, 1'b1, 3, BUSY);
        end
        add(1'b0, 1'b1, 1'b1, 1, ADDR | BUSY);
        add(1'b0, 1'b0, 1'b1, 1, SR | BUSY);
        add(1'b0, 1'b0, 1'b1, 2, MISO | BUSY);
        for (int i = 0; i < 7; i++) begin
            add(1'b0, 1'b1, 1'b1, 1, MISO | BUSY);
            add(1'b0, 1'b0, 1'b1, 3, MISO | BUSY);
        end
        add(1'b0, 1'b1, 1'b1, 1, BUSY);
        add(1'b0, 1'b0, 1'b1, 3, BUSY);
        for (int i = 0; i < 4; i++) begin
            add(1'b0, 1'b1, 1'b1, 1, BUSY);
            add(1'b0, 1'b0, 1'b1, 3, BUSY);
        end
        add(1'b1, 1'b0, 1'b0, 2, NONE);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks %0d", checks);
        $fatal(1, "time limit");
    end

    initial begin
        reset_n = 1'b0;
        cs_n    = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), NONE);
        @(negedge clk);
        reset_n = 1'b1;

        buildWrite();
        runTable("write");

        buildRead();
        runTable("read");

        // cs_n withdrawn after 5 address pulses.
        step("abort_cs", 1'b0, 1'b0, 1'b0, BUSY);
        pulses("abort_addr", 5, 1'b0, BUSY, BUSY);
        step("abort_exit", 1'b1, 1'b0, 1'b0, ABRT);
        step("abort_idle", 1'b1, 1'b0, 1'b0, NONE);

        // cs_n rises together with the 8th write-data pulse.
        step("coin_cs", 1'b0, 1'b0, 1'b0, BUSY);
        pulses("coin_addr", 7, 1'b0, BUSY, BUSY);
        step("coin_a8", 1'b0, 1'b1, 1'b0, ADDR | BUSY);
        repeat (3) step("coin_ws", 1'b0, 1'b0, 1'b0, BUSY);
        pulses("coin_data", 7, 1'b0, BUSY, BUSY);
        step("coin_hit", 1'b1, 1'b1, 1'b0, ABRT);
        repeat (3) step("coin_idle", 1'b1, 1'b0, 1'b0, NONE);

        // Reset in READ_SHIFT after 3 data pulses, then a fresh write.
        step("rst_cs", 1'b0, 1'b0, 1'b1, BUSY);
        pulses("rst_addr", 7, 1'b1, BUSY, BUSY);
        step("rst_a8", 1'b0, 1'b1, 1'b1, ADDR | BUSY);
        step("rst_ld", 1'b0, 1'b0, 1'b1, SR | BUSY);
        repeat (2) step("rst_sh", 1'b0, 1'b0, 1'b1, MISO | BUSY);
        pulses("rst_data", 3, 1'b1, MISO | BUSY, MISO | BUSY);
        #2;
        reset_n = 1'b0;
        #1;
        check("rst_async", outs(), NONE);
        @(negedge clk);
        cs_n    = 1'b0;
        sclk_pe = 1'b0;
        rw_bit  = 1'b0;
        #2;
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_start", outs(), BUSY);
        buildWrite();
        runTable("rst_write");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
